// File: rtl/alu16_pipe.sv
// ---------------------------------------------------------------------------
// alu16_pipe
//
// Hack-style 16-bit ALU followed by a 2-entry in-order result buffer with a
// valid/ready handshake on both sides.
//
// The ALU result and its zr/ng flags are computed combinationally from the
// inputs. They are captured into the buffer on an accepting edge.
//
// Ports
//   clock      : sole clock; all state updates on its rising edge
//   reset      : asynchronous, active-high; clears all state
//   in_valid   : upstream presents an operation
//   in_ready   : an operation can be accepted this cycle (count < 2)
//   x, y       : 16-bit operands
//   zx..no     : Hack ALU control bits
//   out_valid  : head result is valid (count > 0)
//   out_ready  : downstream consumes the head result
//   out        : head result value
//   zr, ng     : head result flags (== 0, bit 15)
//   ops_done   : wrapping count of results consumed downstream
// ---------------------------------------------------------------------------
module alu16_pipe #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      x,
    input  logic [15:0]      y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out,
    output logic             zr,
    output logic             ng,
    output logic [CNT_W-1:0] ops_done
);

    // Buffer entries are packed as {zr, ng, value}.
    localparam int ENT_W = 18;

    logic [1:0]       count_q, count_d;
    logic [ENT_W-1:0] head_q, head_d;
    logic [ENT_W-1:0] spare_q, spare_d;
    logic [CNT_W-1:0] ops_q, ops_d;

    // ALU datapath.
    logic [15:0]      x1, x2, y1, y2, o_val, r_val;
    logic [ENT_W-1:0] new_entry;

    always_comb begin
        x1        = zx ? 16'h0000 : x;
        x2        = nx ? ~x1 : x1;
        y1        = zy ? 16'h0000 : y;
        y2        = ny ? ~y1 : y1;
        o_val     = f ? (x2 + y2) : (x2 & y2);  // 16-bit sum, carry dropped
        r_val     = no ? ~o_val : o_val;
        new_entry = {(r_val == 16'h0000), r_val[15], r_val};
    end

    // Handshake; both ready and valid depend only on registered count.
    logic accept, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // The head register doubles as the output register. It is only
    // overwritten when a newer result becomes head, so when the buffer
    // drains it keeps showing the last popped result.
    always_comb begin
        head_d  = head_q;
        spare_d = spare_q;
        count_d = count_q;
        ops_d   = ops_q;

        if (pop && (count_q == 2'd2)) begin
            head_d = spare_q;
        end else if (accept && ((count_q == 2'd0) || pop)) begin
            head_d = new_entry;
        end else if (accept) begin
            spare_d = new_entry;
        end

        case ({accept, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        if (pop) begin
            ops_d = ops_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= 2'd0;
            head_q  <= '0;
            spare_q <= '0;
            ops_q   <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            spare_q <= spare_d;
            ops_q   <= ops_d;
        end
    end

    assign out      = head_q[15:0];
    assign ng       = head_q[16];
    assign zr       = head_q[17];
    assign ops_done = ops_q;

endmodule
